// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX stage and the iterative multiply/divide unit.
// The unit owns HI/LO and drives busy for the stall logic.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mthi;
   logic             mtlo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, mthi, mtlo,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, mthi, mtlo,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Magnitude datapath: shift-add multiply, restoring divide, sign fix at end.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst_n,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   mb_q, mb_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_top;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
   assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
   assign mag_a = a_neg ? -bus.a : bus.a;
   assign mag_b = b_neg ? -bus.b : bus.b;

   // acc = {partial product, remaining multiplier bits}
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mb_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};

   // acc = {partial remainder, dividend bits / quotient bits}
   assign div_top  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_ge   = div_top >= {1'b0, mb_q};
   assign div_rem  = div_top[WIDTH-1:0] - mb_q;
   assign div_next = div_ge
      ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
      : {div_top[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

   assign mul_res = qneg_q ? -acc_q : acc_q;
   assign q_fix   = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign r_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                           : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.mthi) hi_d = bus.a;
            if (bus.mtlo) lo_d = bus.a;
            if (bus.start) begin
               op_d    = bus.op;
               // b=0 keeps the quotient positive so lo ends as all ones
               qneg_d  = (a_neg ^ b_neg) & (~bus.op[1] | (|bus.b));
               rneg_d  = bus.op[1] & a_neg;
               mb_d    = mag_b;
               acc_d   = {{WIDTH{1'b0}}, mag_a};
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = op_q[1] ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
         end
         FIX: begin
            if (op_q[1]) begin
               hi_d = r_fix;
               lo_d = q_fix;
            end else begin
               hi_d = mul_res[2*WIDTH-1:WIDTH];
               lo_d = mul_res[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         mb_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus
// hand-written sequences for reset, move and busy corner cases.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_unit_if mif ();

   muldiv_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (mif.slave)
   );

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   localparam logic [1:0] MULT  = 2'b00;
   localparam logic [1:0] MULTU = 2'b01;
   localparam logic [1:0] DIV   = 2'b10;
   localparam logic [1:0] DIVU  = 2'b11;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input string name, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int busy_n;
      int done_at;
      busy_n  = 0;
      done_at = 0;
      @(negedge clk);
      mif.op    = op;
      mif.a     = a;
      mif.b     = b;
      mif.start = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      mif.op    = 2'b00;
      mif.a     = 32'h0;
      mif.b     = 32'h0;
      for (int c = 1; c <= 40 && done_at == 0; c++) begin
         if (c > 1) @(negedge clk);
         if (mif.busy) busy_n++;
         if (mif.done) done_at = c;
      end
      chk({name, " busy cycles"}, 32'(busy_n), 32'd33);
      chk({name, " done cycle"}, 32'(done_at), 32'd34);
      chk({name, " hi"}, mif.hi, ehi);
      chk({name, " lo"}, mif.lo, elo);
      @(negedge clk);
      chk({name, " done width"}, {31'b0, mif.done}, 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      int dones;
      int waited;
      vecs[0]  = '{"mult_neg3x5", MULT, 32'hFFFFFFFD, 32'd5,
                   32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1]  = '{"multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001};
      vecs[2]  = '{"div_neg7_2", DIV, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{"divu_by0", DIVU, 32'd7, 32'd0,
                   32'h00000007, 32'hFFFFFFFF};
      vecs[4]  = '{"div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF,
                   32'h00000000, 32'h80000000};
      vecs[5]  = '{"div_7_neg2", DIV, 32'd7, 32'hFFFFFFFE,
                   32'h00000001, 32'hFFFFFFFD};
      vecs[6]  = '{"div_neg7_by0", DIV, 32'hFFFFFFF9, 32'd0,
                   32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7]  = '{"mult_minsq", MULT, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h00000000};
      vecs[8]  = '{"divu_max_1", DIVU, 32'hFFFFFFFF, 32'd1,
                   32'h00000000, 32'hFFFFFFFF};
      vecs[9]  = '{"divu_100_7", DIVU, 32'd100, 32'd7,
                   32'd2, 32'd14};
      vecs[10] = '{"multu_2p16", MULTU, 32'h00010000, 32'h00010000,
                   32'h00000001, 32'h00000000};
      vecs[11] = '{"mult_neg_neg", MULT, 32'hFFFFFFFE, 32'hFFFFFFFD,
                   32'h00000000, 32'h00000006};

      mif.start = 1'b0;
      mif.op    = 2'b00;
      mif.a     = 32'h0;
      mif.b     = 32'h0;
      mif.mthi  = 1'b0;
      mif.mtlo  = 1'b0;

      #1;
      chk("rst busy", {31'b0, mif.busy}, 32'd0);
      chk("rst done", {31'b0, mif.done}, 32'd0);
      chk("rst hi", mif.hi, 32'h0);
      chk("rst lo", mif.lo, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      mif.mthi = 1'b1;
      mif.a    = 32'hA5A5A5A5;
      @(negedge clk);
      mif.mthi = 1'b0;
      mif.mtlo = 1'b1;
      mif.a    = 32'h5A5A5A5A;
      chk("mthi idle hi", mif.hi, 32'hA5A5A5A5);
      chk("mthi idle lo", mif.lo, 32'h0);
      @(negedge clk);
      mif.mtlo = 1'b0;
      chk("mtlo idle lo", mif.lo, 32'h5A5A5A5A);
      chk("mtlo idle hi", mif.hi, 32'hA5A5A5A5);

      for (int i = 0; i < 12; i++)
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo);

      // mthi together with start: move lands at E0, result overwrites
      @(negedge clk);
      mif.op    = MULTU;
      mif.a     = 32'd3;
      mif.b     = 32'd4;
      mif.start = 1'b1;
      mif.mthi  = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      mif.mthi  = 1'b0;
      chk("mthi+start hi at E0", mif.hi, 32'd3);
      chk("mthi+start busy", {31'b0, mif.busy}, 32'd1);
      waited = 0;
      while (!mif.done && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("mthi+start done seen", {31'b0, mif.done}, 32'd1);
      chk("mthi+start hi", mif.hi, 32'd0);
      chk("mthi+start lo", mif.lo, 32'd12);

      // moves while busy must be dropped
      @(negedge clk);
      mif.op    = MULTU;
      mif.a     = 32'd3;
      mif.b     = 32'd5;
      mif.start = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (3) @(negedge clk);
      mif.mtlo = 1'b1;
      mif.mthi = 1'b1;
      mif.a    = 32'hDEADBEEF;
      @(negedge clk);
      mif.mtlo = 1'b0;
      mif.mthi = 1'b0;
      chk("mtlo busy lo", mif.lo, 32'd12);
      chk("mthi busy hi", mif.hi, 32'd0);
      waited = 0;
      while (!mif.done && waited < 40) begin
         @(negedge clk);
         waited++;
         if (!mif.done)
            chk("mtlo busy lo held", mif.lo, 32'd12);
      end
      chk("mtlo busy done seen", {31'b0, mif.done}, 32'd1);
      chk("mtlo busy result lo", mif.lo, 32'd15);
      chk("mtlo busy result hi", mif.hi, 32'd0);

      // second start 5 cycles into a DIVU is ignored
      @(negedge clk);
      mif.op    = DIVU;
      mif.a     = 32'd100;
      mif.b     = 32'd7;
      mif.start = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (4) @(negedge clk);
      mif.op    = MULT;
      mif.a     = 32'd2;
      mif.b     = 32'd3;
      mif.start = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      dones = 0;
      for (int c = 0; c < 70; c++) begin
         if (mif.done) begin
            dones++;
            chk("dbl start lo", mif.lo, 32'd14);
            chk("dbl start hi", mif.hi, 32'd2);
         end
         @(negedge clk);
      end
      chk("dbl start done count", 32'(dones), 32'd1);
      chk("dbl start idle", {31'b0, mif.busy}, 32'd0);

      // asynchronous reset mid-MULT
      @(negedge clk);
      mif.op    = MULT;
      mif.a     = 32'h1234;
      mif.b     = 32'h10;
      mif.start = 1'b1;
      @(negedge clk);
      mif.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre-rst busy", {31'b0, mif.busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst busy", {31'b0, mif.busy}, 32'd0);
      chk("mid rst done", {31'b0, mif.done}, 32'd0);
      chk("mid rst hi", mif.hi, 32'h0);
      chk("mid rst lo", mif.lo, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post rst idle", {31'b0, mif.busy}, 32'd0);
      run_op("mult_after_rst", MULT, 32'h1234, 32'h10,
             32'h0, 32'h00012340);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
